// File: rtl/qam16_demod_buf.sv
// 16-QAM hard-decision demapper: slices signed 4-bit I/Q samples, Gray-demaps them,
// buffers symbols in a FIFO and hands them downstream as I-then-Q dibits.
module qam16_demod_buf #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [3:0]               I_in,
  input  logic [3:0]               Q_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [1:0]               dibit_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         offgrid_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Gray mapping of the nearest level: -3 -> 00, -1 -> 01, +1 -> 11, +3 -> 10.
  function automatic logic [1:0] slice_lvl(input logic signed [3:0] v);
    if (v < -4'sd2)      return 2'b00;
    else if (v < 4'sd0)  return 2'b01;
    else if (v < 4'sd2)  return 2'b11;
    else                 return 2'b10;
  endfunction

  function automatic logic on_grid(input logic signed [3:0] v);
    return (v == -4'sd3) || (v == -4'sd1) || (v == 4'sd1) || (v == 4'sd3);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic signed [3:0] i_p1, q_p1;
  logic              vld_p1;
  logic [3:0]        sym_p1;
  logic              offgrid_p1;

  logic [3:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              phase;
  logic              pop, wr_en, full;
  logic [3:0]        head;

  // ---- stage 1: sample capture ----
  always_ff @(posedge clk) begin
    if (in_valid) begin
      i_p1 <= $signed(I_in);
      q_p1 <= $signed(Q_in);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= in_valid;
  end

  // ---- stage 2: slice, count off-grid, write FIFO ----
  assign sym_p1     = {slice_lvl(i_p1), slice_lvl(q_p1)};
  assign offgrid_p1 = !(on_grid(i_p1) && on_grid(q_p1));

  assign full      = (fifo_level == FULL_LVL);
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready && phase;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign wr_en     = vld_p1 && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sym_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      phase       <= 1'b0;
      offgrid_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (out_valid && out_ready) phase <= !phase;
      if (vld_p1 && offgrid_p1)   offgrid_cnt <= sat_inc(offgrid_cnt);
      if (vld_p1 && !wr_en)       overflow <= 1'b1;
    end
  end

  // ---- output: first-word-fall-through serialiser ----
  assign head      = mem[rd_ptr];
  assign dibit_out = out_valid ? (phase ? head[1:0] : head[3:2]) : 2'b00;

endmodule

// File: tb/tb_qam16_demod_buf.sv
// Directed bench for qam16_demod_buf: slicing table, latency, backpressure/overflow,
// full-with-pop acceptance, counter saturation and mid-symbol asynchronous reset.
module tb_qam16_demod_buf;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [3:0]        I_in, Q_in;
  logic              out_ready;
  logic              out_valid;
  logic [1:0]        dibit_out;
  logic [3:0]        fifo_level;
  logic [CNT_W-1:0]  offgrid_cnt;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic signed [3:0] i;
    logic signed [3:0] q;
    logic [1:0]        exp_i;
    logic [1:0]        exp_q;
  } vec_t;

  vec_t tbl[16];

  logic signed [3:0] lv[4] = '{-4'sd3, -4'sd1, 4'sd1, 4'sd3};
  logic [1:0]        bt[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  qam16_demod_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .I_in       (I_in),
    .Q_in       (Q_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .dibit_out  (dibit_out),
    .fifo_level (fifo_level),
    .offgrid_cnt(offgrid_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [3:0] i, input logic signed [3:0] q);
    in_valid = 1'b1;
    I_in     = i;
    Q_in     = q;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid with out_ready high, checks the dibit, then lets it transfer.
  task automatic recv(input string name, input logic [1:0] exp);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      check(name, 32'(dibit_out), 32'(exp));
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{-4'sd8, 4'sd1, 2'b00, 2'b11};
    tbl[1]  = '{-4'sd7, 4'sd1, 2'b00, 2'b11};
    tbl[2]  = '{-4'sd6, 4'sd1, 2'b00, 2'b11};
    tbl[3]  = '{-4'sd5, 4'sd1, 2'b00, 2'b11};
    tbl[4]  = '{-4'sd4, 4'sd1, 2'b00, 2'b11};
    tbl[5]  = '{-4'sd3, 4'sd1, 2'b00, 2'b11};
    tbl[6]  = '{-4'sd2, 4'sd1, 2'b01, 2'b11};
    tbl[7]  = '{-4'sd1, 4'sd1, 2'b01, 2'b11};
    tbl[8]  = '{ 4'sd0, 4'sd1, 2'b11, 2'b11};
    tbl[9]  = '{ 4'sd1, 4'sd1, 2'b11, 2'b11};
    tbl[10] = '{ 4'sd2, 4'sd1, 2'b10, 2'b11};
    tbl[11] = '{ 4'sd3, 4'sd1, 2'b10, 2'b11};
    tbl[12] = '{ 4'sd4, 4'sd1, 2'b10, 2'b11};
    tbl[13] = '{ 4'sd5, 4'sd1, 2'b10, 2'b11};
    tbl[14] = '{ 4'sd6, 4'sd1, 2'b10, 2'b11};
    tbl[15] = '{ 4'sd7, 4'sd1, 2'b10, 2'b11};

    reset = 1'b0; in_valid = 1'b0; I_in = '0; Q_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid",   32'(out_valid),   32'd0);
    check("rst dibit_out",   32'(dibit_out),   32'd0);
    check("rst fifo_level",  32'(fifo_level),  32'd0);
    check("rst offgrid_cnt", 32'(offgrid_cnt), 32'd0);
    check("rst overflow",    32'(overflow),    32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single clean symbol I=+3, Q=-1 with latency checks.
    out_ready = 1'b1;
    in_valid = 1'b1; I_in = 4'sd3; Q_in = -4'sd1;
    tick();
    in_valid = 1'b0;
    check("lat capture out_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat write out_valid", 32'(out_valid), 32'd1);
    check("clean I dibit",       32'(dibit_out), 32'b10);
    check("clean fifo_level",    32'(fifo_level), 32'd1);
    tick();
    check("clean Q dibit",       32'(dibit_out), 32'b01);
    check("clean Q out_valid",   32'(out_valid), 32'd1);
    tick();
    check("clean drained out_valid", 32'(out_valid),  32'd0);
    check("clean drained level",     32'(fifo_level), 32'd0);
    check("clean drained dibit",     32'(dibit_out),  32'd0);
    check("clean offgrid_cnt",       32'(offgrid_cnt), 32'd0);

    // Slicing sweep of I over -8..7 with Q=+1.
    for (int k = 0; k < 16; k++) begin
      send(tbl[k].i, tbl[k].q);
      recv($sformatf("sweep I=%0d Idibit", tbl[k].i), tbl[k].exp_i);
      recv($sformatf("sweep I=%0d Qdibit", tbl[k].i), tbl[k].exp_q);
    end
    check("sweep offgrid_cnt", 32'(offgrid_cnt), 32'd12);
    check("sweep fifo_level",  32'(fifo_level),  32'd0);

    // Off-grid counter saturates at 15 for CNT_W=4.
    for (int k = 0; k < 5; k++) begin
      send(4'sd0, 4'sd0);
      recv("sat Idibit", 2'b11);
      recv("sat Qdibit", 2'b11);
      if (k == 2) check("sat offgrid 15", 32'(offgrid_cnt), 32'd15);
    end
    check("sat offgrid held", 32'(offgrid_cnt), 32'd15);

    // Backpressure: 10 samples into an 8-deep FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; I_in = lv[k % 4]; Q_in = lv[(k + 1) % 4];
      tick();
      check($sformatf("bp level k=%0d", k), 32'(fifo_level), (k < 8) ? 32'(k) : 32'd8);
      check($sformatf("bp overflow k=%0d", k), 32'(overflow), (k == 9) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("bp full level",    32'(fifo_level), 32'd8);
    check("bp overflow held", 32'(overflow),   32'd1);
    check("bp hold dibit",    32'(dibit_out),  32'(bt[0]));
    tick();
    check("bp hold dibit 2",  32'(dibit_out),  32'(bt[0]));
    check("bp hold valid",    32'(out_valid),  32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      recv($sformatf("bp sym%0d I", k), bt[k % 4]);
      recv($sformatf("bp sym%0d Q", k), bt[(k + 1) % 4]);
    end
    check("bp drained level",  32'(fifo_level), 32'd0);
    check("bp drained valid",  32'(out_valid),  32'd0);
    check("bp overflow stays", 32'(overflow),   32'd1);

    // Full FIFO with a pop on the same edge as the write.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(lv[k % 4], lv[(k + 1) % 4]);
    tick();
    check("fp full level", 32'(fifo_level), 32'd8);
    out_ready = 1'b1;
    in_valid = 1'b1; I_in = 4'sd3; Q_in = -4'sd3;
    tick();
    in_valid = 1'b0;
    check("fp phase1 dibit", 32'(dibit_out),  32'(bt[1]));
    check("fp phase1 level", 32'(fifo_level), 32'd8);
    tick();
    check("fp pop+write level", 32'(fifo_level), 32'd8);
    check("fp overflow clear",  32'(overflow),   32'd0);
    for (int k = 1; k < 8; k++) begin
      recv($sformatf("fp sym%0d I", k), bt[k % 4]);
      recv($sformatf("fp sym%0d Q", k), bt[(k + 1) % 4]);
    end
    recv("fp new I", 2'b10);
    recv("fp new Q", 2'b00);
    check("fp drained level", 32'(fifo_level), 32'd0);
    check("fp overflow end",  32'(overflow),   32'd0);

    // Reset asserted after only the I dibit has been accepted.
    do_reset();
    out_ready = 1'b1;
    send(4'sd1, -4'sd1);
    recv("mid I dibit", 2'b11);
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid rst out_valid", 32'(out_valid),  32'd0);
    check("mid rst level",     32'(fifo_level), 32'd0);
    check("mid rst dibit",     32'(dibit_out),  32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    send(-4'sd3, 4'sd3);
    recv("post rst I", 2'b00);
    recv("post rst Q", 2'b10);
    check("post rst level",   32'(fifo_level),  32'd0);
    check("post rst offgrid", 32'(offgrid_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
